// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter (LSB first, idle-high txd).
// txd is registered from the FSM state, so it trails each state change by one clock.
module uart_tx_fifo #(
   parameter int DIVIDER    = 217,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    wr_data,
   input  logic                          wr_en,
   output logic                          full,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   output logic                          txd
);

   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [11:0] BAUD_LAST = 12'(DIVIDER - 1);
   localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   state_t      state_q, state_d;
   logic [11:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        txd_q, txd_d;
   logic        overflow_q, overflow_d;
   logic        empty, push, pop, baud_done;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level     = wr_ptr_q - rd_ptr_q;
   assign busy      = !empty || (state_q != IDLE);
   assign push      = wr_en && !full;
   assign baud_done = (baud_q == BAUD_LAST);
   assign overflow  = overflow_q;
   assign txd       = txd_q;

   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      pop        = 1'b0;
      overflow_d = wr_en && full;
      wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q[AW-1:0]];
               baud_d  = '0;
               state_d = START;
            end
         end
         START: begin
            if (baud_done) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + 12'd1;
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end else begin
               baud_d = baud_q + 12'd1;
            end
         end
         default: begin
            if (baud_done) begin
               baud_d = '0;
               // Chain straight into the next start bit when more data is queued.
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q[AW-1:0]];
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + 12'd1;
            end
         end
      endcase
      rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      case (state_q)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_q[0];
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         baud_q     <= '0;
         bit_q      <= '0;
         txd_q      <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         txd_q      <= txd_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage and shifter hold data only; the control state decides validity.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      shift_q <= shift_d;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: a frame-timing reference model checked every
// cycle, a mid-bit UART monitor, and a DIVIDER=2 / depth-2 waveform check.
module tb_uart_tx_fifo;

   localparam int D      = 217;
   localparam int DEPTH  = 4;
   localparam int FRAME  = 10 * D;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] wr_data_a, wr_data_b;
   logic       wr_en_a, wr_en_b;
   logic       full_a, busy_a, overflow_a, txd_a;
   logic       full_b, busy_b, overflow_b, txd_b;
   logic [2:0] level_a;
   logic [1:0] level_b;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DIVIDER(D), .FIFO_DEPTH(DEPTH)) dut_a (
      .clk(clk), .rst_n(rst_n), .wr_data(wr_data_a), .wr_en(wr_en_a),
      .full(full_a), .busy(busy_a), .level(level_a), .overflow(overflow_a), .txd(txd_a));

   uart_tx_fifo #(.DIVIDER(2), .FIFO_DEPTH(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .wr_data(wr_data_b), .wr_en(wr_en_b),
      .full(full_b), .busy(busy_b), .level(level_b), .overflow(overflow_b), .txd(txd_b));

   int cyc   = 0;
   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  tag, obs, obs, exp, exp, cyc);
      end
   endtask

   // Reference model: each accepted byte starts its frame at
   // max(write_edge + 2, previous_start + FRAME); everything else follows from that.
   int         m_t[$];
   logic [7:0] m_b[$];
   int         drop_edge = -1;
   int         mdl_held, mdl_t;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst_n) begin
         m_t.delete();
         m_b.delete();
         drop_edge = -1;
      end else if (wr_en_a) begin
         mdl_held = 0;
         foreach (m_t[j]) if (m_t[j] - 1 >= cyc) mdl_held++;
         if (mdl_held == DEPTH) begin
            drop_edge = cyc;
         end else begin
            mdl_t = cyc + 2;
            if (m_t.size() > 0 && m_t[m_t.size()-1] + FRAME > mdl_t)
               mdl_t = m_t[m_t.size()-1] + FRAME;
            m_t.push_back(mdl_t);
            m_b.push_back(wr_data_a);
         end
      end
   end

   int         e_lvl, e_busy, e_txd, e_k;
   logic [7:0] e_byte;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_txd", txd_a, 1);
         chk("rst_busy", busy_a, 0);
         chk("rst_level", level_a, 0);
         chk("rst_full", full_a, 0);
         chk("rst_overflow", overflow_a, 0);
      end else begin
         e_lvl  = 0;
         e_busy = 0;
         e_txd  = 1;
         foreach (m_t[j]) begin
            if (m_t[j] - 1 > cyc) e_lvl++;
            if (cyc < m_t[j] - 1 + FRAME) e_busy = 1;
            if (cyc >= m_t[j] && cyc < m_t[j] + FRAME) begin
               e_k = (cyc - m_t[j]) / D;
               e_byte = m_b[j];
               if (e_k == 0) e_txd = 0;
               else if (e_k <= 8) e_txd = int'(e_byte[e_k-1]);
            end
         end
         chk("txd", txd_a, e_txd);
         chk("level", level_a, e_lvl);
         chk("full", full_a, int'(e_lvl == DEPTH));
         chk("busy", busy_a, e_busy);
         chk("overflow", overflow_a, int'(drop_edge == cyc));
      end
   end

   // Mid-bit UART receiver on dut_a.
   bit         mon_act  = 1'b0;
   bit         mon_prev = 1'b1;
   int         mon_s, mon_k;
   int         mon_ferr = 0;
   logic [7:0] mon_sh;
   logic [7:0] rx_b[$];
   int         rx_t[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_act  = 1'b0;
         mon_prev = 1'b1;
      end else if (!mon_act) begin
         if (mon_prev && !txd_a) begin
            mon_act = 1'b1;
            mon_s   = cyc;
            mon_k   = 0;
         end
         mon_prev = txd_a;
      end else if (cyc == mon_s + mon_k * D + D / 2) begin
         if (mon_k >= 1 && mon_k <= 8) begin
            mon_sh[mon_k-1] = txd_a;
         end else if (mon_k == 9) begin
            if (txd_a) begin
               rx_b.push_back(mon_sh);
               rx_t.push_back(mon_s);
            end else begin
               mon_ferr++;
            end
            mon_act  = 1'b0;
            mon_prev = txd_a;
         end
         mon_k++;
      end
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic wr_a(input logic [7:0] d);
      wr_en_a   = 1'b1;
      wr_data_a = d;
      step();
      wr_en_a   = 1'b0;
      wr_data_a = 8'($urandom);
   endtask

   task automatic wait_rx(input int cnt, input int lim);
      int k = 0;
      while (rx_b.size() < cnt && k < lim) begin
         step();
         k++;
      end
   endtask

   function automatic int rx_at(input int i);
      if (i < rx_b.size()) return int'(rx_b[i]);
      return -1;
   endfunction

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   string      s3 = "S1S2DN";
   logic [7:0] e4[5];
   int         n, k, exp_b;

   initial begin
      rst_n     = 1'b0;
      wr_en_a   = 1'b0;
      wr_en_b   = 1'b0;
      wr_data_a = 8'h00;
      wr_data_b = 8'h00;
      repeat (5) step();
      rst_n = 1'b1;

      // Idle after reset: no start edge, line stays high.
      repeat (100) step();
      chk("t1_rx_count", rx_b.size(), 0);
      chk("t1_txd", txd_a, 1);

      // Single 'S' frame.
      wr_a(8'h53);
      n = cyc;
      wait_rx(1, 3 * FRAME);
      while (cyc < n + 2 + FRAME) step();
      chk("t2_busy_end", busy_a, 0);
      chk("t2_rx_count", rx_b.size(), 1);
      chk("t2_byte", rx_at(0), 'h53);
      chk("t2_start", (rx_t.size() > 0) ? rx_t[0] : -1, n + 2);

      // Six bytes, each written once full is clear, with random gaps.
      rx_b.delete();
      rx_t.delete();
      for (int i = 0; i < 6; i++) begin
         k = 0;
         while (full_a && k < 5000) begin
            step();
            k++;
         end
         wr_a(s3[i]);
         repeat ($urandom_range(0, 3)) step();
      end
      wait_rx(6, 8 * FRAME);
      repeat (300) step();
      chk("t3_rx_count", rx_b.size(), 6);
      for (int i = 0; i < 6; i++) chk("t3_byte", rx_at(i), int'(s3[i]));
      for (int i = 1; i < 6 && i < rx_t.size(); i++)
         chk("t3_spacing", rx_t[i] - rx_t[i-1], FRAME);

      // Fill the FIFO behind a frame in flight, then overflow once.
      rx_b.delete();
      rx_t.delete();
      e4[0] = 8'($urandom);
      wr_a(e4[0]);
      repeat (300) step();
      for (int i = 1; i < 5; i++) begin
         e4[i] = 8'($urandom);
         wr_a(e4[i]);
      end
      chk("t4_full", full_a, 1);
      chk("t4_level", level_a, 4);
      wr_a(8'hEE);
      chk("t4_overflow_pulse", overflow_a, 1);
      step();
      chk("t4_overflow_clear", overflow_a, 0);
      wait_rx(5, 7 * FRAME);
      repeat (FRAME + 500) step();
      chk("t4_rx_count", rx_b.size(), 5);
      for (int i = 0; i < 5; i++) chk("t4_byte", rx_at(i), int'(e4[i]));

      // Reset in the middle of data bit 4 of 0xA5.
      rx_b.delete();
      rx_t.delete();
      wr_a(8'hA5);
      n = cyc;
      while (cyc < n + 2 + 5 * D + 100) step();
      rst_n = 1'b0;
      #1;
      chk("t5_txd_async", txd_a, 1);
      chk("t5_level_async", level_a, 0);
      chk("t5_busy_async", busy_a, 0);
      repeat (3) step();
      rst_n = 1'b1;
      repeat (10) step();
      wr_a(8'h32);
      wait_rx(1, 3 * FRAME);
      repeat (500) step();
      chk("t5_rx_count", rx_b.size(), 1);
      chk("t5_byte", rx_at(0), 'h32);
      chk("framing_errors", mon_ferr, 0);

      // DIVIDER=2, depth 2: 0x00 then 0xFF back to back.
      chk("t6_idle_txd", txd_b, 1);
      chk("t6_idle_busy", busy_b, 0);
      wr_en_b   = 1'b1;
      wr_data_b = 8'h00;
      step();
      n = cyc;
      wr_data_b = 8'hFF;
      step();
      wr_en_b = 1'b0;
      chk("t6_level", level_b, 1);
      chk("t6_overflow", overflow_b, 0);
      for (int e = n + 1; e <= n + 45; e++) begin
         if (e < n + 2)       exp_b = 1;
         else if (e < n + 20) exp_b = 0;
         else if (e < n + 22) exp_b = 1;
         else if (e < n + 24) exp_b = 0;
         else                 exp_b = 1;
         chk("t6_txd", txd_b, exp_b);
         step();
      end
      chk("t6_busy_end", busy_b, 0);
      chk("t6_level_end", level_b, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
